// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RISC-V M-extension execute unit with a registered multiply and a
// radix-2 restoring divider. Optional macro MULDIV_DIV_EARLY_EXIT_EN retires div-by-zero/overflow at accept.

package muldiv_pkg;
  typedef enum logic [3:0] {
    FN_ADD    = 4'd0,
    FN_SUB    = 4'd1,
    FN_SLL    = 4'd2,
    FN_SLT    = 4'd3,
    FN_XOR    = 4'd4,
    FN_SRL    = 4'd5,
    FN_OR     = 4'd6,
    FN_AND    = 4'd7,
    FN_MUL    = 4'd8,
    FN_MULH   = 4'd9,
    FN_MULHSU = 4'd10,
    FN_MULHU  = 4'd11,
    FN_DIV    = 4'd12,
    FN_DIVU   = 4'd13,
    FN_REM    = 4'd14,
    FN_REMU   = 4'd15
  } AluFunc;
endpackage

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  AluFunc          func_in,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic [4:0]      dst_in,
  input  logic            kill_in,
  output logic            valid_out,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      dst_out
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DIV_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_r, state_s;
  AluFunc          func_r;
  logic [XLEN-1:0] a_r, b_r;
  logic [4:0]      op_dst_r;
  logic [XLEN-1:0] quo_r, rem_r, dvsr_r;
  logic [CW-1:0]   count_r;
  logic            neg_q_r, neg_r_r;
  logic [XLEN-1:0] result_r;
  logic [4:0]      dst_r;

  logic            accept_s;
  logic            div_op_in_s, signed_div_in_s;
  logic            a_neg_in_s, b_neg_in_s, div_zero_in_s;
  logic [XLEN-1:0] a_mag_in_s, b_mag_in_s;

  logic                   a_sext_s, b_sext_s;
  logic signed [2*XLEN-1:0] ma_s, mb_s, prod_s;
  logic [XLEN-1:0]        mul_result_s;

  logic [XLEN:0]   shifted_s, diff_s;
  logic            ge_s;
  logic [XLEN-1:0] q_fixed_s, r_fixed_s, div_result_s;

  logic            load_result_s;
  logic [XLEN-1:0] result_next_s;
  logic [4:0]      dst_next_s;

  // Operand classification and magnitudes, evaluated on the raw inputs for the accept edge
  assign accept_s        = (state_r == S_IDLE) && valid_in && !kill_in;
  assign div_op_in_s     = func_in inside {FN_DIV, FN_DIVU, FN_REM, FN_REMU};
  assign signed_div_in_s = (func_in == FN_DIV) || (func_in == FN_REM);
  assign a_neg_in_s      = signed_div_in_s && a_in[XLEN-1];
  assign b_neg_in_s      = signed_div_in_s && b_in[XLEN-1];
  assign a_mag_in_s      = a_neg_in_s ? (-a_in) : a_in;
  assign b_mag_in_s      = b_neg_in_s ? (-b_in) : b_in;
  assign div_zero_in_s   = (b_in == '0);

`ifdef MULDIV_DIV_EARLY_EXIT_EN
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic            overflow_in_s, early_in_s;
  logic [XLEN-1:0] early_result_s;

  assign overflow_in_s = signed_div_in_s && (a_in == INT_MIN) && (b_in == '1);
  assign early_in_s    = div_zero_in_s || overflow_in_s;

  // Architectural result for the two divide corner cases
  always_comb begin
    early_result_s = '0;
    if ((func_in == FN_DIV) || (func_in == FN_DIVU)) begin
      early_result_s = div_zero_in_s ? '1 : INT_MIN;
    end else begin
      early_result_s = div_zero_in_s ? a_in : '0;
    end
  end
`endif

  // Product of sign/zero-extended operands; low half is identical for all signedness modes
  assign a_sext_s = ((func_r == FN_MULH) || (func_r == FN_MULHSU)) && a_r[XLEN-1];
  assign b_sext_s = (func_r == FN_MULH) && b_r[XLEN-1];
  assign ma_s     = {{XLEN{a_sext_s}}, a_r};
  assign mb_s     = {{XLEN{b_sext_s}}, b_r};
  assign prod_s   = ma_s * mb_s;

  // Select the product half requested by the latched function
  always_comb begin
    mul_result_s = '0;
    case (func_r)
      FN_MUL:                       mul_result_s = prod_s[XLEN-1:0];
      FN_MULH, FN_MULHSU, FN_MULHU: mul_result_s = prod_s[2*XLEN-1:XLEN];
      default:                      mul_result_s = '0;
    endcase
  end

  // Restoring step: a clear borrow bit means the shifted remainder covers the divisor
  assign shifted_s = {rem_r, quo_r[XLEN-1]};
  assign diff_s    = shifted_s - {1'b0, dvsr_r};
  assign ge_s      = ~diff_s[XLEN];

  // A zero divisor leaves an all-ones quotient and |a| remainder, so only the quotient sign is gated
  assign q_fixed_s = neg_q_r ? (-quo_r) : quo_r;
  assign r_fixed_s = neg_r_r ? (-rem_r) : rem_r;

  // Quotient or remainder depending on the latched function
  always_comb begin
    div_result_s = r_fixed_s;
    if ((func_r == FN_DIV) || (func_r == FN_DIVU)) begin
      div_result_s = q_fixed_s;
    end else begin
      div_result_s = r_fixed_s;
    end
  end

  // Next-state logic and result load control
  always_comb begin
    state_s       = state_r;
    load_result_s = 1'b0;
    result_next_s = '0;
    dst_next_s    = op_dst_r;
    if (kill_in) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (valid_in) begin
            if (div_op_in_s) begin
`ifdef MULDIV_DIV_EARLY_EXIT_EN
              if (early_in_s) begin
                state_s       = S_DONE;
                load_result_s = 1'b1;
                result_next_s = early_result_s;
                dst_next_s    = dst_in;
              end else begin
                state_s = S_DIV;
              end
`else
              state_s = S_DIV;
`endif
            end else begin
              state_s = S_MUL;
            end
          end else begin
            state_s = S_IDLE;
          end
        end
        S_MUL: begin
          state_s       = S_DONE;
          load_result_s = 1'b1;
          result_next_s = mul_result_s;
        end
        S_DIV: begin
          if (count_r == LAST_COUNT) begin
            state_s = S_FIX;
          end else begin
            state_s = S_DIV;
          end
        end
        S_FIX: begin
          state_s       = S_DONE;
          load_result_s = 1'b1;
          result_next_s = div_result_s;
        end
        S_DONE:  state_s = S_IDLE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // State, operand latch, divider datapath and result registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r  <= S_IDLE;
      func_r   <= FN_ADD;
      a_r      <= '0;
      b_r      <= '0;
      op_dst_r <= 5'd0;
      quo_r    <= '0;
      rem_r    <= '0;
      dvsr_r   <= '0;
      count_r  <= '0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      result_r <= '0;
      dst_r    <= 5'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        func_r   <= func_in;
        a_r      <= a_in;
        b_r      <= b_in;
        op_dst_r <= dst_in;
        quo_r    <= a_mag_in_s;
        dvsr_r   <= b_mag_in_s;
        rem_r    <= '0;
        count_r  <= '0;
        neg_q_r  <= (a_neg_in_s ^ b_neg_in_s) && !div_zero_in_s;
        neg_r_r  <= a_neg_in_s;
      end else if ((state_r == S_DIV) && !kill_in) begin
        quo_r   <= {quo_r[XLEN-2:0], ge_s};
        rem_r   <= ge_s ? diff_s[XLEN-1:0] : shifted_s[XLEN-1:0];
        count_r <= count_r + CW'(1);
      end else begin
        count_r <= count_r;
      end
      if (load_result_s) begin
        result_r <= result_next_s;
        dst_r    <= dst_next_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign ready_out  = (state_r == S_IDLE);
  assign valid_out  = (state_r == S_DONE) && !kill_in;
  assign result_out = result_r;
  assign dst_out    = dst_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, kill/reset scenarios and
// randomized ops compared against an arithmetic reference model.

module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_in, valid_in, kill_in;
  logic        ready_out, valid_out;
  AluFunc      func_in;
  logic [31:0] a_in, b_in, result_out;
  logic [4:0]  dst_in, dst_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .DIV_CYCLES(32)) dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .func_in   (func_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .dst_in    (dst_in),
    .kill_in   (kill_in),
    .valid_out (valid_out),
    .result_out(result_out),
    .dst_out   (dst_out)
  );

  function automatic logic [31:0] ref_model(input AluFunc f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    logic [31:0]     r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 32'd0;
    case (f)
      FN_MUL:    begin p = sa * sb; r = p[31:0]; end
      FN_MULH:   begin p = sa * sb; r = p[63:32]; end
      FN_MULHSU: begin p = sa * longint'(ub); r = p[63:32]; end
      FN_MULHU:  begin up = ua * ub; r = up[63:32]; end
      FN_DIV: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == INT_MIN && b == 32'hFFFF_FFFF) r = INT_MIN;
        else begin p = sa / sb; r = p[31:0]; end
      end
      FN_DIVU: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin up = ua / ub; r = up[31:0]; end
      end
      FN_REM: begin
        if (b == 32'd0) r = a;
        else if (a == INT_MIN && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      FN_REMU: begin
        if (b == 32'd0) r = a;
        else begin up = ua % ub; r = up[31:0]; end
      end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input AluFunc f, input logic [31:0] a, input logic [31:0] b);
    bit is_div;
    is_div = (f == FN_DIV) || (f == FN_DIVU) || (f == FN_REM) || (f == FN_REMU);
    if (!is_div) return 2;
`ifdef MULDIV_DIV_EARLY_EXIT_EN
    if (b == 32'd0) return 1;
    if ((f == FN_DIV || f == FN_REM) && a == INT_MIN && b == 32'hFFFF_FFFF) return 1;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return INT_MIN;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one op from IDLE, then follow it to its result pulse and back to IDLE
  task automatic run_op(input AluFunc f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input string tag);
    logic [31:0] exp_res;
    int          lat, cyc;
    bit          seen;
    exp_res = ref_model(f, a, b);
    lat     = exp_lat(f, a, b);
    check({tag, "_ready_before"}, 32'(ready_out), 32'd1);
    valid_in = 1'b1;
    func_in  = f;
    a_in     = a;
    b_in     = b;
    dst_in   = d;
    tick();
    valid_in = 1'b0;
    func_in  = AluFunc'(4'($urandom_range(0, 15)));
    a_in     = $urandom;
    b_in     = $urandom;
    dst_in   = 5'($urandom_range(0, 31));
    check({tag, "_busy_c1"}, 32'(ready_out), 32'd0);
    cyc  = 1;
    seen = 1'b0;
    while (cyc < 60 && !seen) begin
      if (valid_out === 1'b1) seen = 1'b1;
      else begin
        tick();
        cyc++;
      end
    end
    check({tag, "_valid_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_result"}, result_out, exp_res);
    check({tag, "_dst"}, 32'(dst_out), 32'(d));
    tick();
    check({tag, "_single_pulse"}, 32'(valid_out), 32'd0);
    check({tag, "_ready_after"}, 32'(ready_out), 32'd1);
  endtask

  initial begin
    AluFunc      f;
    logic [31:0] ra, rb;
    int          pulses;

    rst_in   = 1'b1;
    valid_in = 1'b0;
    kill_in  = 1'b0;
    func_in  = FN_ADD;
    a_in     = 32'd0;
    b_in     = 32'd0;
    dst_in   = 5'd0;
    repeat (3) tick();
    check("rst_ready", 32'(ready_out), 32'd1);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_result", result_out, 32'd0);
    check("rst_dst", 32'(dst_out), 32'd0);
    rst_in = 1'b0;
    tick();

    run_op(FN_MULH, 32'hFFFF_FFFF, 32'd2, 5'd1, "mulh");
    check("mulh_hold", result_out, 32'hFFFF_FFFF);
    run_op(FN_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd2, "mulhu");
    check("mulhu_hold", result_out, 32'd1);
    run_op(FN_MUL, 32'hFFFF_FFFF, 32'd2, 5'd3, "mul");
    check("mul_hold", result_out, 32'hFFFF_FFFE);
    run_op(FN_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, "mulhsu");
    run_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, "div_neg7");
    check("div_neg7_hold", result_out, 32'hFFFF_FFFD);
    run_op(FN_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem_neg7");
    check("rem_neg7_hold", result_out, 32'hFFFF_FFFF);
    run_op(FN_DIVU, 32'd100, 32'd7, 5'd7, "divu100");
    check("divu100_hold", result_out, 32'd14);
    run_op(FN_REMU, 32'd100, 32'd7, 5'd8, "remu100");
    check("remu100_hold", result_out, 32'd2);
    run_op(FN_DIVU, 32'd5, 32'd0, 5'd9, "divu_by0");
    check("divu_by0_hold", result_out, 32'hFFFF_FFFF);
    run_op(FN_REM, 32'd5, 32'd0, 5'd10, "rem_by0");
    check("rem_by0_hold", result_out, 32'd5);
    run_op(FN_DIV, 32'hFFFF_FFFB, 32'd0, 5'd11, "div_neg_by0");
    run_op(FN_DIV, INT_MIN, 32'hFFFF_FFFF, 5'd12, "div_ovf");
    check("div_ovf_hold", result_out, INT_MIN);
    run_op(FN_REM, INT_MIN, 32'hFFFF_FFFF, 5'd13, "rem_ovf");
    check("rem_ovf_hold", result_out, 32'd0);
    run_op(FN_ADD, 32'd5, 32'd6, 5'd14, "non_m");

    // kill at cycle 10 of a divide, then an immediate MUL
    valid_in = 1'b1; func_in = FN_DIV; a_in = 32'd1000; b_in = 32'd3; dst_in = 5'd20;
    tick();
    valid_in = 1'b0;
    repeat (9) tick();
    kill_in = 1'b1;
    #1;
    check("kill_div_valid", 32'(valid_out), 32'd0);
    tick();
    kill_in = 1'b0;
    check("kill_div_ready", 32'(ready_out), 32'd1);
    check("kill_div_novalid", 32'(valid_out), 32'd0);
    run_op(FN_MUL, 32'd3, 32'd4, 5'd21, "mul_after_kill");
    check("mul_after_kill_hold", result_out, 32'd12);

    // kill while the result pulse is showing
    valid_in = 1'b1; func_in = FN_MUL; a_in = 32'd7; b_in = 32'd8; dst_in = 5'd22;
    tick();
    valid_in = 1'b0;
    tick();
    check("done_pulse_pre", 32'(valid_out), 32'd1);
    kill_in = 1'b1;
    #1;
    check("kill_done_valid", 32'(valid_out), 32'd0);
    tick();
    kill_in = 1'b0;
    check("kill_done_ready", 32'(ready_out), 32'd1);
    check("kill_done_novalid", 32'(valid_out), 32'd0);

    // kill in IDLE blocks the accept
    valid_in = 1'b1; kill_in = 1'b1; func_in = FN_MUL; a_in = 32'd2; b_in = 32'd2; dst_in = 5'd23;
    tick();
    valid_in = 1'b0; kill_in = 1'b0;
    check("kill_idle_ready", 32'(ready_out), 32'd1);
    tick();
    check("kill_idle_c2", 32'(valid_out), 32'd0);
    tick();
    check("kill_idle_c3", 32'(valid_out), 32'd0);

    // reset (with kill) at cycle 20 of a divide
    valid_in = 1'b1; func_in = FN_DIVU; a_in = 32'hDEAD_BEEF; b_in = 32'd5; dst_in = 5'd24;
    tick();
    valid_in = 1'b0;
    repeat (19) tick();
    rst_in = 1'b1; kill_in = 1'b1;
    tick();
    rst_in = 1'b0; kill_in = 1'b0;
    check("rst_mid_ready", 32'(ready_out), 32'd1);
    check("rst_mid_valid", 32'(valid_out), 32'd0);
    check("rst_mid_result", result_out, 32'd0);
    check("rst_mid_dst", 32'(dst_out), 32'd0);
    pulses = 0;
    repeat (40) begin
      if (valid_out === 1'b1) pulses++;
      tick();
    end
    check("rst_mid_no_pulse", pulses, 0);

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      f  = AluFunc'(4'($urandom_range(0, 15)));
      ra = pick_operand();
      rb = pick_operand();
      run_op(f, ra, rb, 5'($urandom_range(0, 31)), "rand");
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
